// File: rtl/whr_ni_tx_if.sv
// Local-node side of the network-interface transmitter: packet descriptor
// handshake plus the payload data stream handshake.
interface whr_ni_tx_if #(
  parameter int addr_width           = 4,
  parameter int payload_length_width = 2,
  parameter int flit_data_width      = 64
);
  logic                            pkt_valid;
  logic                            pkt_ready;
  logic [addr_width-1:0]           pkt_dest;
  logic [payload_length_width-1:0] pkt_length;
  logic                            data_valid;
  logic                            data_ready;
  logic [flit_data_width-1:0]      data_in;

  // Local node: offers descriptors and payload data.
  modport master (
    output pkt_valid, pkt_dest, pkt_length, data_valid, data_in,
    input  pkt_ready, data_ready
  );

  // Transmitter: accepts descriptors and payload data.
  modport slave (
    input  pkt_valid, pkt_dest, pkt_length, data_valid, data_in,
    output pkt_ready, data_ready
  );
endinterface

// File: rtl/whr_ni_tx.sv
// Wormhole-router network-interface transmitter. Turns a descriptor plus a
// payload stream into explicit-length flits {link_ctrl, valid, head, data}
// and tracks the credits of the downstream router input buffer.
// Head flit data is MSB-aligned: the top addr_width bits carry the
// destination, the next payload_length_width bits the encoded length.
module whr_ni_tx #(
  parameter int buffer_size        = 8,
  parameter int flit_data_width    = 64,
  parameter int addr_width         = 4,
  parameter int max_payload_length = 4,
  parameter int min_payload_length = 1,
  parameter bit enable_link_pm     = 1'b1,
  localparam int payload_length_width = $clog2(max_payload_length - min_payload_length + 1),
  localparam int link_ctrl_width      = enable_link_pm ? 1 : 0,
  localparam int channel_width        = link_ctrl_width + 2 + flit_data_width,
  localparam int credit_width         = $clog2(buffer_size + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  whr_ni_tx_if.slave               tx_if,
  output logic [channel_width-1:0] channel_out,
  input  logic                     flow_ctrl_in,
  output logic [credit_width-1:0]  credit_count,
  output logic                     error
);

  localparam int rem_width = $clog2(max_payload_length + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  localparam logic [credit_width-1:0] CREDITS_FULL = credit_width'(buffer_size);
  localparam logic [rem_width-1:0]    REM_MIN      = rem_width'(min_payload_length);
  localparam logic [rem_width-1:0]    REM_ONE      = rem_width'(1);

  logic [0:0]                 state_q, state_d;
  logic [credit_width-1:0]    credits_q, credits_d;
  logic [rem_width-1:0]       remaining_q, remaining_d;
  logic                       flit_valid_q, flit_valid_d;
  logic                       flit_head_q, flit_head_d;
  logic [flit_data_width-1:0] flit_data_q, flit_data_d;
  logic                       error_q, error_d;

  logic                       have_credit;
  logic                       pkt_fire;
  logic                       data_fire;
  logic                       sent;
  logic [flit_data_width-1:0] head_data;

  // Ready depends on registered state only, never on the returning credit.
  assign have_credit      = (credits_q != '0);
  assign tx_if.pkt_ready  = (state_q == ST_IDLE) && have_credit;
  assign tx_if.data_ready = (state_q == ST_BODY) && have_credit;

  assign pkt_fire  = tx_if.pkt_valid  && tx_if.pkt_ready;
  assign data_fire = tx_if.data_valid && tx_if.data_ready;
  assign sent      = pkt_fire || data_fire;

  // Build the head flit payload: destination, then length, then zeros.
  always_comb begin
    head_data = '0;
    head_data[flit_data_width-1 -: addr_width] = tx_if.pkt_dest;
    head_data[flit_data_width-addr_width-1 -: payload_length_width] = tx_if.pkt_length;
  end

  // Next-state logic for the packet FSM, flit register and credit counter.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    remaining_d  = remaining_q;
    flit_valid_d = 1'b0;
    flit_head_d  = 1'b0;
    flit_data_d  = '0;
    credits_d    = credits_q;
    error_d      = 1'b0;

    if (pkt_fire) begin
      flit_valid_d = 1'b1;
      flit_head_d  = 1'b1;
      flit_data_d  = head_data;
      remaining_d  = rem_width'(tx_if.pkt_length) + REM_MIN;
      state_d      = (remaining_d != '0) ? ST_BODY : ST_IDLE;
    end else if (data_fire) begin
      flit_valid_d = 1'b1;
      flit_data_d  = tx_if.data_in;
      remaining_d  = remaining_q - REM_ONE;
      if (remaining_q == REM_ONE) begin
        state_d = ST_IDLE;
      end
    end

    // A send and a returned credit in the same cycle cancel out.
    if (sent && !flow_ctrl_in) begin
      credits_d = credits_q - 1'b1;
    end else if (!sent && flow_ctrl_in) begin
      if (credits_q == CREDITS_FULL) begin
        error_d = 1'b1;
      end else begin
        credits_d = credits_q + 1'b1;
      end
    end
  end

  // State, counter and output flit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      credits_q    <= CREDITS_FULL;
      remaining_q  <= '0;
      flit_valid_q <= 1'b0;
      flit_head_q  <= 1'b0;
      flit_data_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other register.
      state_q      <= state_d;
      credits_q    <= credits_d;
      remaining_q  <= remaining_d;
      flit_valid_q <= flit_valid_d;
      flit_head_q  <= flit_head_d;
      flit_data_q  <= flit_data_d;
      error_q      <= error_d;
    end
  end

  assign credit_count = credits_q;
  assign error        = error_q;

  if (enable_link_pm) begin : g_link
    logic link_ctrl_q;

    // Keep the link awake while a packet is pending or in flight.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        link_ctrl_q <= 1'b0;
      end else begin
        link_ctrl_q <= (state_q == ST_BODY) || tx_if.pkt_valid;
      end
    end

    assign channel_out = {link_ctrl_q, flit_valid_q, flit_head_q, flit_data_q};
  end else begin : g_no_link
    assign channel_out = {flit_valid_q, flit_head_q, flit_data_q};
  end

endmodule
